// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit owning HI/LO; one shift-add or restoring step per cycle.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle combinational multiplier.
module ex_muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              wr_hi,
   input  logic              wr_lo,
   input  logic              id_hilo_use,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              stall_req,
   output logic [1:0]        dbg_state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic                is_div_q, is_div_d;
   logic                neg_q, neg_d;
   logic                rem_neg_q, rem_neg_d;
   logic                dz_q, dz_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                done_q, done_d;

   logic                sgn_op, a_neg, b_neg;
   logic [DATA_W-1:0]   a_abs, b_abs;
   logic [DATA_W:0]     mul_sum, rem_sh, rem_diff;
   logic [2*DATA_W-1:0] mul_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      sgn_op   = ~op[0];
      a_neg    = sgn_op & rs_val[DATA_W-1];
      b_neg    = sgn_op & rt_val[DATA_W-1];
      a_abs    = a_neg ? -rs_val : rs_val;
      b_abs    = b_neg ? -rt_val : rt_val;
      mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
      rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      mul_fix  = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      rem_fix  = rem_neg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      b_d       = b_q;
      acc_d     = acc_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!flush) begin
               if (start) begin
                  cnt_d     = '0;
                  is_div_d  = op[1];
                  neg_d     = a_neg ^ b_neg;
                  rem_neg_d = a_neg;
                  dz_d      = (rt_val == '0);
                  state_d   = S_RUN;
                  if (op[1]) begin
                     acc_d = {{DATA_W{1'b0}}, a_abs};
                     b_d   = b_abs;
                  end else begin
                     acc_d = {{DATA_W{1'b0}}, b_abs};
                     b_d   = a_abs;
`ifdef MULDIV_FAST_MUL_EN
                     acc_d   = {{DATA_W{1'b0}}, a_abs} * {{DATA_W{1'b0}}, b_abs};
                     state_d = S_FIX;
`endif
                  end
               end else begin
                  if (wr_hi) hi_d = rs_val;
                  if (wr_lo) lo_d = rs_val;
               end
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (is_div_q) begin
                  if (!rem_diff[DATA_W]) acc_d = {rem_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                  else                   acc_d = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
               end else begin
                  acc_d = {mul_sum, acc_q[DATA_W-1:1]};
               end
               if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = dz_q ? '1 : quo_fix;
               end else begin
                  hi_d = mul_fix[2*DATA_W-1:DATA_W];
                  lo_d = mul_fix[DATA_W-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign stall_req = busy & id_hilo_use;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table of mul/div results plus flush, MTHI/MTLO and reset sequences.
module tb_ex_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] rs_val = '0;
   logic [W-1:0] rt_val = '0;
   logic         wr_hi = 1'b0;
   logic         wr_lo = 1'b0;
   logic         id_hilo_use = 1'b0;
   logic [W-1:0] hi, lo;
   logic         busy, done, stall_req;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   ex_muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .wr_hi(wr_hi), .wr_lo(wr_lo),
      .id_hilo_use(id_hilo_use), .hi(hi), .lo(lo), .busy(busy), .done(done),
      .stall_req(stall_req), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endfunction

   function automatic void chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Launches one op, scrambles operands/start/MTHI/MTLO while it runs, then checks result and timing.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit noise);
      int lat, bad_busy, bad_stall;
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b; id_hilo_use = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rs_val = $urandom; rt_val = $urandom;
      lat = 0; bad_busy = 0; bad_stall = 0;
      while (!done && lat < 200) begin
         if (busy !== 1'b1) bad_busy++;
         if (stall_req !== busy) bad_stall++;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom_range(0, 3));
            wr_hi = 1'($urandom_range(0, 1));
            wr_lo = 1'($urandom_range(0, 1));
            rs_val = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      chk_int({tag, "_latency"}, lat, o[1] ? DIV_LAT : MUL_LAT);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
      chk_bit({tag, "_busy_at_done"}, busy, 1'b0);
      chk_bit({tag, "_stall_at_done"}, stall_req, 1'b0);
      chk_int({tag, "_busy_gaps"}, bad_busy, 0);
      chk_int({tag, "_stall_mismatch"}, bad_stall, 0);
      @(posedge clk); #1;
      chk_bit({tag, "_done_one_cycle"}, done, 1'b0);
      id_hilo_use = 1'b0;
   endtask

   initial begin
      int n_done;
      //            op     a              b              hi             lo
      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
      vecs[6]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
      vecs[10] = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
      vecs[11] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};

      // reset state
      id_hilo_use = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk_bit("rst_stall", stall_req, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      id_hilo_use = 1'b0;

      for (int i = 0; i < NV; i++) begin
         do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].exp_hi, vecs[i].exp_lo, (i % 2) == 1);
      end

      // MTHI / MTLO in IDLE, single and together
      @(negedge clk); wr_lo = 1'b1; rs_val = 32'h0000BBBB;
      @(negedge clk); wr_lo = 1'b0;
      chk("mtlo_lo", lo, 32'h0000BBBB);
      chk("mtlo_hi_kept", hi, vecs[NV-1].exp_hi);
      @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; rs_val = 32'h5A5A1234;
      @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
      chk("mthilo_hi", hi, 32'h5A5A1234);
      chk("mthilo_lo", lo, 32'h5A5A1234);
      @(negedge clk); wr_hi = 1'b1; rs_val = 32'hAAAA0000;
      @(negedge clk); wr_hi = 1'b0;
      chk("mthi_hi", hi, 32'hAAAA0000);

      // flush in the middle of a DIVU
      @(negedge clk); start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk_bit("flush_busy_before", busy, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk_bit("flush_busy_after", busy, 1'b0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      chk_int("flush_no_done", n_done, 0);
      chk("flush_hi_kept", hi, 32'hAAAA0000);
      chk("flush_lo_kept", lo, 32'h5A5A1234);

      // flush beats start in IDLE
      @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd4;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      chk_bit("flush_start_busy", busy, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_start_lo_kept", lo, 32'h5A5A1234);

      // asynchronous reset in the middle of an op
      @(negedge clk); start = 1'b1; op = 2'b11; rs_val = 32'h0000FFFF; rt_val = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk_bit("mid_rst_busy_before", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk_bit("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_hi", hi, '0);
      chk("mid_rst_lo", lo, '0);
      chk_bit("mid_rst_done", done, 1'b0);
      @(negedge clk); reset = 1'b1;
      do_op("post_rst_multu", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, fed from the ID/EX pipeline register outputs (operand buses, funct-decoded op).
- Owns the architectural HI/LO registers and supplies them to MFHI/MFLO.
- Exports a stall request to the hazard unit while an operation is in flight, so ID/EX is bubbled instead of issuing a dependent instruction.

Parameters:
- DATA_W, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  abort the in-flight op; from the branch/exception flush logic.
- start  input  1  EX instruction is MULT/MULTU/DIV/DIVU; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  input  DATA_W  operand A (dividend/multiplicand), forwarded EX value.
- rt_val  input  DATA_W  operand B (divisor/multiplier).
- wr_hi, wr_lo  input  1 each  MTHI/MTLO write enables; data is rs_val.
- id_hilo_use  input  1  ID instruction reads/writes HI/LO or is a muldiv op.
- hi, lo  output  DATA_W each  architectural HI/LO.
- busy  output  1  op in progress (RUN or FIX state).
- done  output  1  one-cycle pulse; HI/LO just updated by an op.
- stall_req  output  1  combinational: busy & id_hilo_use.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared. Reset mid-op discards the op.
- FSM states:
  - IDLE: on start, latch |A|, |B| (signed ops) or raw operands (unsigned ops), result signs, and op; go to RUN with cnt=0.
  - RUN: one iteration per cycle for DATA_W cycles.
    - Multiply: shift-add into a 2*DATA_W product.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - cnt==DATA_W-1 -> FIX.
  - FIX: apply sign correction and write hi/lo. Then go to IDLE with done=1 for exactly one cycle.
- Latency: start sampled at edge k; busy=1 from edge k until edge k+DATA_W+1; hi/lo/done valid after edge k+DATA_W+1 (33 cycles for DATA_W=32).
- Signs:
  - MULT: product negated iff signs differ.
  - DIV: quotient negated iff signs differ; remainder takes the dividend's sign.
- Results: HI=upper product / remainder; LO=lower product / quotient.
- Divide by zero: LO=all ones, HI=dividend (rs_val as latched); still takes full latency.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- Priority in a cycle: reset > flush > start > wr_hi/wr_lo.
  - flush in RUN/FIX: return to IDLE next edge; hi/lo unchanged; no done.
  - flush with start in IDLE: start ignored.
- start while busy: ignored.
- wr_hi/wr_lo while busy: ignored (stall_req prevents them in normal flow).
- wr_hi/wr_lo in IDLE: update the selected register at the next edge; both may assert together.
- Operands are latched at start; later changes on rs_val/rt_val have no effect.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU are computed by a single-cycle combinational multiplier. IDLE goes directly to FIX; hi/lo/done are valid after edge k+1 and busy is high for one cycle. Divide is unchanged.
- Undefined: all ops are iterative as above.

Test Plan:
- MULTU 0xFFFFFFFF x 0x00000002 -> busy for 33 cycles, then HI=0x00000001, LO=0xFFFFFFFE, done pulses once. With MULDIV_FAST_MUL_EN: same values after 1 cycle.
- MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA0000 then DIVU 100/7 started; flush asserted at cycle 10 -> busy drops next edge, HI=0xAAAA0000 retained, no done.
- During an op, id_hilo_use=1 -> stall_req=1 every busy cycle and 0 the cycle after done. A start pulse mid-op leaves the result unaffected.
- reset driven low at cycle 20 of an op -> hi=lo=0, busy=0 immediately (asynchronous). After release, a new MULTU 3 x 4 gives LO=12.
